encoder_8x3: RTL and testbench
==============================

Name: encoder_8x3

Overview:
- Registered 8-to-3 one-hot binary encoder with a validity flag.
- Accepts an 8-bit one-hot request vector and outputs the 3-bit index of the single asserted bit.
- Flags zero-hot and multi-hot inputs as invalid rather than prioritising them.
- Sits between one-hot select/grant logic and binary-indexed consumers (mux selects, address fields).

Parameters:
- None. Input width is fixed at 8 and output width at 3.

Ports:
- clk    input   1  system clock, rising-edge active
- rst    input   1  asynchronous reset, active-high
- in     input   8  one-hot request vector; bit i set means index i is requested
- out    output  3  registered binary index of the single set bit of in; 3'b000 when invalid
- valid  output  1  registered; 1 when in had exactly one bit set
- err    output  1  registered; 1 when in had two or more bits set

Behaviour:
- Reset:
  - rst is asynchronous and active-high.
  - While rst=1: out=3'b000, valid=0, err=0, regardless of clk or in.
  - Deassertion takes effect at the first rising clk edge after rst falls.
- Combinational decode of in, evaluated every cycle:
  - Count the set bits of in (popcount, 0..8).
  - Exactly one bit set at position i: next_out=i (3-bit binary), next_valid=1, next_err=0.
  - Zero bits set: next_out=3'b000, next_valid=0, next_err=0.
  - Two or more bits set: next_out=3'b000, next_valid=0, next_err=1.
  - No priority resolution: multi-hot never yields a nonzero index.
- Latency:
  - out, valid and err are captured on the rising edge of clk.
  - Outputs reflect the in value sampled at the previous rising edge, i.e. 1-cycle latency.
  - Input changes between edges have no effect until the next edge.
- Mapping for valid one-hot inputs:
  - in=0x01->0, 0x02->1, 0x04->2, 0x08->3, 0x10->4, 0x20->5, 0x40->6, 0x80->7.
- Invariants:
  - valid and err are never both 1.
  - out is nonzero only when valid=1.
  - An index of 0 with valid=1 is distinct from the invalid case (out=0, valid=0).
- Back-to-back operation:
  - A new input is accepted every cycle; no handshake or stall.
  - Outputs hold when in is held.
- Reset mid-operation: outputs clear immediately (asynchronously) and no partial state persists. After release, the first edge samples the current in.
- No X-propagation on outputs after reset, even if in was X before the first post-reset edge.

Test Plan:
- Reset:
  - Drive in=0xFF, assert rst asynchronously between edges -> out=000, valid=0, err=0 immediately.
  - Release rst; the next edge gives err=1.
- Zero input: in=0x00 for 2 cycles -> out=000, valid=0, err=0.
- One-hot sweep:
  - in=0x01,0x02,...,0x80, one per cycle -> one cycle later out=0..7 in order, valid=1, err=0 each cycle.
- Multi-hot:
  - in=0x03 -> out=000, valid=0, err=1.
  - in=0x28 -> out=000, valid=0, err=1.
  - in=0xFF -> out=000, valid=0, err=1.
- Latency and timing:
  - Change in mid-cycle from 0x10 to 0x40 -> out stays 4 until the next rising edge, then becomes 6.
  - Glitching in between edges does not alter outputs.
- Exhaustive check: all 256 in values, one per cycle -> each registered output matches the popcount-based reference model one cycle later; valid&err is never 1.

Source files
------------

// File: rtl/encoder_8x3.sv
// -----------------------------------------------------------------------------
// encoder_8x3
//
// Registered 8-to-3 one-hot encoder with a validity flag. The block converts a
// one-hot request vector into the binary index of its single set bit. It flags
// zero-hot and multi-hot vectors as invalid. It does not pick one of the set
// bits by priority. The block takes a new vector every cycle. All outputs
// appear one clock after the vector is sampled.
//
// Ports:
//   clk    in   1  system clock, rising-edge active
//   rst    in   1  asynchronous reset, active-high
//   in     in   8  one-hot request vector; bit i set requests index i
//   out    out  3  registered index of the single set bit; 0 when invalid
//   valid  out  1  registered; 1 when in had exactly one bit set
//   err    out  1  registered; 1 when in had two or more bits set
// -----------------------------------------------------------------------------
module encoder_8x3 (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] in,
    output logic [2:0] out,
    output logic       valid,
    output logic       err
);

    logic [3:0] ones;      // popcount of in, 0..8
    logic [2:0] idx;       // position of a set bit; meaningful only when ones == 1

    logic [2:0] out_d,   out_q;
    logic       valid_d, valid_q;
    logic       err_d,   err_q;

    // Decode the request vector combinationally from the current input.
    always_comb begin
        // NOTE: each variable gets a default before any conditional update.
        // Without the default, a path that skips the assignment infers a latch.
        ones    = '0;
        idx     = '0;
        out_d   = '0;
        valid_d = 1'b0;
        err_d   = 1'b0;

        for (int i = 0; i < 8; i++) begin
            ones = ones + {3'b000, in[i]};
            if (in[i]) begin
                idx = 3'(i);
            end
        end

        // The index is forwarded only when exactly one bit is set. For a
        // multi-hot vector, idx holds some set bit, but the block must not
        // expose it.
        if (ones == 4'd1) begin
            out_d   = idx;
            valid_d = 1'b1;
        end else if (ones > 4'd1) begin
            err_d   = 1'b1;
        end
    end

    // Output registers. Reset clears them asynchronously, so reset takes
    // effect right away and leaves no state from before it. The first edge
    // after release samples whatever value is then on in.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: state registers use non-blocking assignments. All flops then
        // update together from values sampled before the edge.
        if (rst) begin
            out_q   <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            out_q   <= out_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

    assign out   = out_q;
    assign valid = valid_q;
    assign err   = err_q;

endmodule

// File: tb/tb_encoder_8x3.sv
module tb_encoder_8x3;

    logic       clk;
    logic       rst;
    logic [7:0] in;
    logic [2:0] out;
    logic       valid;
    logic       err;

    int n_checks = 0;
    int n_errors = 0;

    encoder_8x3 dut (
        .clk   (clk),
        .rst   (rst),
        .in    (in),
        .out   (out),
        .valid (valid),
        .err   (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model. It counts the set bits and, when exactly one bit is
    // set, finds the power of two that equals the vector.
    function automatic void model(input logic [7:0] v,
                                  output logic [2:0] e_out,
                                  output logic       e_valid,
                                  output logic       e_err);
        int cnt;
        cnt     = 0;
        e_out   = 3'd0;
        e_valid = 1'b0;
        e_err   = 1'b0;
        for (int b = 0; b < 8; b++) cnt += int'(v[b]);
        if (cnt == 1) begin
            e_valid = 1'b1;
            for (int j = 0; j < 8; j++) if (int'(v) == (1 << j)) e_out = 3'(j);
        end else if (cnt >= 2) begin
            e_err = 1'b1;
        end
    endfunction

    // Apply a vector on the falling edge, then return 1 time unit after the
    // rising edge that captures it.
    task automatic apply(input logic [7:0] v);
        @(negedge clk);
        in = v;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        // Power-on reset state.
        rst = 1'b1;
        in  = 8'hFF;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if ({out, valid, err} !== 5'b000_0_0) begin
            n_errors++;
            $display("FAIL reset_initial: got out=%0d valid=%0b err=%0b, want 0 0 0", out, valid, err);
        end
        // Release reset with in=0xFF. The next edge must flag an error.
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        n_checks++;
        if ({out, valid, err} !== 5'b000_0_1) begin
            n_errors++;
            $display("FAIL reset_release_ff: got out=%0d valid=%0b err=%0b, want 0 0 1", out, valid, err);
        end
        // Assert reset between edges. The outputs must clear immediately.
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if ({out, valid, err} !== 5'b000_0_0) begin
            n_errors++;
            $display("FAIL reset_async_assert: got out=%0d valid=%0b err=%0b, want 0 0 0", out, valid, err);
        end
        // Hold reset across an edge with a valid one-hot input applied.
        in = 8'h20;
        @(posedge clk);
        #1;
        n_checks++;
        if ({out, valid, err} !== 5'b000_0_0) begin
            n_errors++;
            $display("FAIL reset_hold: got out=%0d valid=%0b err=%0b, want 0 0 0", out, valid, err);
        end
        // Release reset. The first edge samples the current input.
        @(negedge clk);
        rst = 1'b0;
        in  = 8'hFF;
        @(posedge clk);
        #1;
        n_checks++;
        if ({out, valid, err} !== 5'b000_0_1) begin
            n_errors++;
            $display("FAIL reset_rerelease: got out=%0d valid=%0b err=%0b, want 0 0 1", out, valid, err);
        end
    endtask

    task automatic test_zero();
        for (int k = 0; k < 2; k++) begin
            apply(8'h00);
            n_checks++;
            if ({out, valid, err} !== 5'b000_0_0) begin
                n_errors++;
                $display("FAIL zero_input[%0d]: got out=%0d valid=%0b err=%0b, want 0 0 0", k, out, valid, err);
            end
        end
    endtask

    task automatic test_onehot_sweep();
        for (int k = 0; k < 8; k++) begin
            logic [7:0] v;
            v = 8'd1 << k;
            apply(v);
            n_checks++;
            if (out !== 3'(k) || valid !== 1'b1 || err !== 1'b0) begin
                n_errors++;
                $display("FAIL onehot_sweep in=%02h: got out=%0d valid=%0b err=%0b, want %0d 1 0", v, out, valid, err, k);
            end
        end
    endtask

    task automatic test_multihot();
        logic [7:0] vecs [3];
        vecs[0] = 8'h03;
        vecs[1] = 8'h28;
        vecs[2] = 8'hFF;
        foreach (vecs[k]) begin
            apply(vecs[k]);
            n_checks++;
            if ({out, valid, err} !== 5'b000_0_1) begin
                n_errors++;
                $display("FAIL multihot in=%02h: got out=%0d valid=%0b err=%0b, want 0 0 1", vecs[k], out, valid, err);
            end
        end
    endtask

    task automatic test_latency();
        apply(8'h10);
        n_checks++;
        if (out !== 3'd4 || valid !== 1'b1 || err !== 1'b0) begin
            n_errors++;
            $display("FAIL latency_setup: got out=%0d valid=%0b err=%0b, want 4 1 0", out, valid, err);
        end
        // Change the input mid-cycle and glitch it. The outputs must hold.
        #1 in = 8'h40;
        #1;
        n_checks++;
        if (out !== 3'd4 || valid !== 1'b1) begin
            n_errors++;
            $display("FAIL latency_midcycle: got out=%0d valid=%0b, want 4 1", out, valid);
        end
        in = 8'hFF;
        #1 in = 8'h00;
        #1 in = 8'h40;
        #1;
        n_checks++;
        if (out !== 3'd4 || valid !== 1'b1 || err !== 1'b0) begin
            n_errors++;
            $display("FAIL latency_glitch: got out=%0d valid=%0b err=%0b, want 4 1 0", out, valid, err);
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (out !== 3'd6 || valid !== 1'b1 || err !== 1'b0) begin
            n_errors++;
            $display("FAIL latency_next_edge: got out=%0d valid=%0b err=%0b, want 6 1 0", out, valid, err);
        end
    endtask

    task automatic test_exhaustive();
        logic [2:0] e_out;
        logic       e_valid, e_err;
        for (int v = 0; v < 256; v++) begin
            apply(8'(v));
            model(8'(v), e_out, e_valid, e_err);
            n_checks++;
            if (out !== e_out || valid !== e_valid || err !== e_err) begin
                n_errors++;
                $display("FAIL exhaustive in=%02h: got out=%0d valid=%0b err=%0b, want %0d %0b %0b",
                         v, out, valid, err, e_out, e_valid, e_err);
            end
            n_checks++;
            if ((valid & err) !== 1'b0) begin
                n_errors++;
                $display("FAIL exhaustive_invariant in=%02h: valid&err=%0b, want 0", v, valid & err);
            end
        end
    endtask

    task automatic test_back_to_back_random();
        logic [2:0] e_out;
        logic       e_valid, e_err;
        logic [7:0] v;
        for (int k = 0; k < 300; k++) begin
            // Half of the vectors are one-hot, so the valid path gets
            // frequent coverage.
            if ($urandom_range(1, 0) == 1) v = 8'd1 << $urandom_range(7, 0);
            else                           v = 8'($urandom);
            apply(v);
            model(v, e_out, e_valid, e_err);
            n_checks++;
            if (out !== e_out || valid !== e_valid || err !== e_err) begin
                n_errors++;
                $display("FAIL random[%0d] in=%02h: got out=%0d valid=%0b err=%0b, want %0d %0b %0b",
                         k, v, out, valid, err, e_out, e_valid, e_err);
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        in  = 8'h00;
        test_reset();
        test_zero();
        test_onehot_sweep();
        test_multihot();
        test_latency();
        test_exhaustive();
        test_back_to_back_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
